// File: rtl/teller_call_dispatcher.sv
// Teller-side front end for the single-bank queue manager: captures "next" presses
// from three tellers, arbitrates them round-robin and emits one clean down_count pulse per call.
module teller_call_dispatcher #(
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       Resetn,
  input  logic [2:0] teller_on,
  input  logic [2:0] next_n,
  input  logic       empty_flag,
  output logic       down_count,
  output logic [1:0] tcount,
  output logic       no_teller,
  output logic       call_valid,
  output logic [1:0] call_id,
  output logic [2:0] serving
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] LP_PULSE = 4'(PULSE_CYC);
  localparam logic [3:0] LP_GAP   = 4'(GAP_CYC);

  logic [1:0] r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [2:0] r_next_prev;
  logic [2:0] r_pending;
  logic [2:0] r_serving;
  logic       r_down;
  logic       r_cv;
  logic [1:0] r_call_id;

  logic [1:0] w_popcnt;
  logic [2:0] w_fall;
  logic [2:0] w_cand;
  logic [1:0] w_o0, w_o1, w_o2;
  logic       w_grant;
  logic [1:0] w_gidx;
  logic [2:0] w_gmask;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    w_popcnt  = {1'b0, teller_on[0]} + {1'b0, teller_on[1]} + {1'b0, teller_on[2]};
    tcount    = (w_popcnt == 2'd0) ? 2'd1 : w_popcnt;
    no_teller = (teller_on == 3'b000);
  end

  assign w_fall = r_next_prev & ~next_n;
  // An off-duty teller is never granted, even if its pending bit has not been cleared yet.
  assign w_cand = r_pending & teller_on;

  always_comb begin
    w_o0 = r_ptr;
    w_o1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_o2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
    w_grant = 1'b0;
    w_gidx  = 2'd0;
    if (r_state == S_IDLE && !empty_flag) begin
      if (w_cand[w_o0]) begin
        w_grant = 1'b1;
        w_gidx  = w_o0;
      end else if (w_cand[w_o1]) begin
        w_grant = 1'b1;
        w_gidx  = w_o1;
      end else if (w_cand[w_o2]) begin
        w_grant = 1'b1;
        w_gidx  = w_o2;
      end
    end
    w_gmask = w_grant ? (3'b001 << w_gidx) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= 4'd0;
      r_next_prev <= 3'b111;
      r_pending   <= 3'b000;
      r_serving   <= 3'b000;
      r_down      <= 1'b1;
      r_cv        <= 1'b0;
      r_call_id   <= 2'd0;
    end else begin
      r_next_prev <= next_n;
      r_pending   <= (r_pending | w_fall) & ~w_gmask & teller_on;
      r_serving   <= (r_serving | w_gmask) & teller_on;
      r_cv        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_PULSE;
            r_down    <= 1'b0;
            r_cv      <= 1'b1;
            r_call_id <= w_gidx + 2'd1;
            r_ptr     <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
            r_cnt     <= 4'd1;
          end
        end
        S_PULSE: begin
          if (r_cnt >= LP_PULSE) begin
            r_down  <= 1'b1;
            r_state <= S_GAP;
            r_cnt   <= 4'd1;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_GAP: begin
          if (r_cnt >= LP_GAP) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_down  <= 1'b1;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign down_count = r_down;
  assign call_valid = r_cv;
  assign call_id    = r_call_id;
  assign serving    = r_serving;

endmodule
